pattern_gen: RTL and testbench
==============================

PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 Parameter DATA_W, default 32: output data width; SHALL be >= CNT_W.
REQ-002 Parameter CNT_W, default 16: pattern register width.
REQ-003 Parameter LFSR_TAPS, default 16'hB400: Galois LFSR feedback mask, CNT_W bits wide.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst_l  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-007 abort  input  1  terminate the current burst.
REQ-008 mode  input  2  pattern select: 0 INCR, 1 LFSR, 2 WALK1, 3 CONST.
REQ-009 seed  input  CNT_W  first pattern value.
REQ-010 step  input  CNT_W  INCR increment.
REQ-011 burst_len  input  16  beats per burst; 0 = unbounded.
REQ-012 out_ready  input  1  downstream accept.
REQ-013 out_valid  output  1  out_data is valid.
REQ-014 out_data  output  DATA_W  {zeros, pattern}, zero-extended.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  one-cycle pulse after the final beat of a bounded burst.

Function
REQ-017 FSM states IDLE, RUN, DONE; start in IDLE -> RUN next cycle; mode, seed, step and burst_len latched on the same edge.
REQ-018 start outside IDLE ignored; input changes after latch have no effect until the next burst.
REQ-019 On entry to RUN, pattern = seed, except in LFSR/WALK1, where seed 0 is replaced by 1.
REQ-020 In RUN, out_valid = 1; a beat transfers on the edge where out_valid & out_ready.
REQ-021 out_data held stable while out_valid & !out_ready.
REQ-022 On each transfer, pattern advances:
- INCR: pattern + step mod 2^CNT_W
- LFSR: if lsb then (pattern >> 1) ^ LFSR_TAPS, else pattern >> 1
- WALK1: rotate left by 1
- CONST: unchanged
REQ-023 Beat counter (16 bit) clears on RUN entry and increments per transfer.
REQ-024 Bounded burst: the transfer with count == burst_len-1 moves RUN -> DONE; DONE lasts 1 cycle with done = 1, then -> IDLE.
REQ-025 burst_len == 0: counter wraps 0xFFFF -> 0; RUN persists until abort.
REQ-026 abort in RUN or DONE: -> IDLE next cycle, no done pulse, no further transfer beyond the current edge; abort in IDLE ignored.
REQ-027 abort and start together in IDLE: start wins.
REQ-028 Latency start -> first out_valid = 1 cycle; no bubbles between back-to-back beats while out_ready = 1.
REQ-029 In IDLE/DONE, out_valid = 0; out_data holds last value.

Reset
REQ-030 rst_l low at a rising edge: state IDLE, pattern 0, counter 0, out_valid 0, out_data 0, busy 0, done 0.
REQ-031 Reset mid-burst abandons the burst, with no done pulse; reset has priority over all inputs.

Structure
REQ-032 Package pattern_gen_pkg holds the mode enum (INCR/LFSR/WALK1/CONST) and the FSM state enum.
REQ-033 Sub-module pattern_gen_step, purely combinational, computes the next pattern from (mode, pattern, step, LFSR_TAPS).

Verification
REQ-034 INCR, seed 0xFFFE, step 3, len 3, out_ready = 1 -> out_data 0x0000FFFE, 0x00000001, 0x00000004; done on the cycle after the 3rd beat.
REQ-035 LFSR, seed 0, len 3 -> 0x0001, 0xB400, 0x5A00.
REQ-036 WALK1, seed 0x8000, len 2, out_ready low for 3 cycles then high -> 0x8000 held 3 cycles, then 0x0001; done once.
REQ-037 CONST, seed 0x1234, len 0, 70000 beats -> data constant, no done; abort -> out_valid 0 next cycle, IDLE.
REQ-038 rst_l low during beat 2 of a len-5 burst -> all outputs 0 next edge; a new start after release begins from the new seed.
REQ-039 start pulsed during RUN with different seed -> ignored; running sequence unchanged.

Source files
------------

// File: rtl/pattern_gen_pkg.sv
// rtl/pattern_gen_pkg.sv - shared types for the burst pattern generator
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_WALK1 = 2'd2,
    MODE_CONST = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int BEAT_W = 16;

endpackage

// File: rtl/pattern_gen_step.sv
// rtl/pattern_gen_step.sv - combinational next-pattern function for each mode
module pattern_gen_step
  import pattern_gen_pkg::*;
#(
  parameter int                CNT_W     = 16,
  parameter logic [CNT_W-1:0]  LFSR_TAPS = 16'hB400
) (
  input  mode_e              mode,
  input  logic [CNT_W-1:0]   pattern,
  input  logic [CNT_W-1:0]   step,
  output logic [CNT_W-1:0]   pattern_next
);

  always_comb begin
    pattern_next = pattern;
    case (mode)
      MODE_INCR:  pattern_next = pattern + step;
      // Galois form: shift right, fold the taps in when a 1 falls out
      MODE_LFSR:  pattern_next = pattern[0] ? ((pattern >> 1) ^ LFSR_TAPS) : (pattern >> 1);
      MODE_WALK1: pattern_next = {pattern[CNT_W-2:0], pattern[CNT_W-1]};
      MODE_CONST: pattern_next = pattern;
      default:    pattern_next = pattern;
    endcase
  end

endmodule

// File: rtl/pattern_gen.sv
// rtl/pattern_gen.sv - burst pattern source with valid/ready output handshake
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                CNT_W     = 16,
  parameter logic [CNT_W-1:0]  LFSR_TAPS = 16'hB400
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   seed,
  input  logic [CNT_W-1:0]   step,
  input  logic [BEAT_W-1:0]  burst_len,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               busy,
  output logic               done
);

  state_e              state;
  mode_e               mode_q;
  logic [CNT_W-1:0]    step_q;
  logic [BEAT_W-1:0]   len_q;
  logic [BEAT_W-1:0]   count;
  logic [CNT_W-1:0]    pattern;
  logic [CNT_W-1:0]    pattern_next;
  logic [CNT_W-1:0]    pattern_init;
  logic                xfer;
  logic                last_beat;

  pattern_gen_step #(
    .CNT_W     (CNT_W),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_step (
    .mode         (mode_q),
    .pattern      (pattern),
    .step         (step_q),
    .pattern_next (pattern_next)
  );

  // An all-zero seed would lock up the LFSR and walk nothing in WALK1
  always_comb begin
    pattern_init = seed;
    if ((mode_e'(mode) == MODE_LFSR || mode_e'(mode) == MODE_WALK1) && seed == '0)
      pattern_init = {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign xfer      = out_valid & out_ready;
  assign last_beat = (len_q != '0) && (count == len_q - 1'b1);

  always_comb begin
    out_data = '0;
    out_data[CNT_W-1:0] = pattern;
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_INCR;
      step_q    <= '0;
      len_q     <= '0;
      count     <= '0;
      pattern   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= ST_RUN;
            mode_q    <= mode_e'(mode);
            step_q    <= step;
            len_q     <= burst_len;
            count     <= '0;
            pattern   <= pattern_init;
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_RUN: begin
          if (xfer)
            count <= count + 1'b1;
          if (abort) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (xfer && last_beat) begin
            // Pattern is not advanced so out_data keeps the final beat
            state     <= ST_DONE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (xfer) begin
            pattern <= pattern_next;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// tb/tb_pattern_gen.sv - directed vector bench for pattern_gen
module tb_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        start;
  logic        abort;
  logic [1:0]  mode;
  logic [15:0] seed;
  logic [15:0] step;
  logic [15:0] burst_len;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] seed;
    logic [15:0] step;
    logic [15:0] len;
    logic [31:0] exp [4];
  } vec_t;

  vec_t vecs [7];

  pattern_gen dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .seed      (seed),
    .step      (step),
    .burst_len (burst_len),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] m, input logic [15:0] s, input logic [15:0] st,
                        input logic [15:0] len);
    start = 1'b1; mode = m; seed = s; step = st; burst_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    out_ready = 1'b1;
    launch(vecs[idx].mode, vecs[idx].seed, vecs[idx].step, vecs[idx].len);
    chk($sformatf("v%0d_busy", idx), {31'b0, busy}, 32'd1);
    for (int i = 0; i < int'(vecs[idx].len); i++) begin
      chk($sformatf("v%0d_valid%0d", idx, i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("v%0d_data%0d", idx, i), out_data, vecs[idx].exp[i]);
      tick();
    end
    chk($sformatf("v%0d_done", idx), {31'b0, done}, 32'd1);
    chk($sformatf("v%0d_valid_end", idx), {31'b0, out_valid}, 32'd0);
    tick();
    chk($sformatf("v%0d_done_clr", idx), {31'b0, done}, 32'd0);
    chk($sformatf("v%0d_busy_end", idx), {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int bad;
    int dones;

    vecs[0] = '{2'd0, 16'hFFFE, 16'd3,      16'd3, '{32'h0000FFFE, 32'h00000001, 32'h00000004, 32'h0}};
    vecs[1] = '{2'd1, 16'h0000, 16'd0,      16'd3, '{32'h00000001, 32'h0000B400, 32'h00005A00, 32'h0}};
    vecs[2] = '{2'd2, 16'h0000, 16'd0,      16'd4, '{32'h00000001, 32'h00000002, 32'h00000004, 32'h00000008}};
    vecs[3] = '{2'd1, 16'h0003, 16'd0,      16'd3, '{32'h00000003, 32'h0000B401, 32'h0000EE00, 32'h0}};
    vecs[4] = '{2'd0, 16'h0000, 16'h8000,   16'd2, '{32'h00000000, 32'h00008000, 32'h0, 32'h0}};
    vecs[5] = '{2'd0, 16'h55AA, 16'd1,      16'd1, '{32'h000055AA, 32'h0, 32'h0, 32'h0}};
    vecs[6] = '{2'd3, 16'hABCD, 16'd7,      16'd2, '{32'h0000ABCD, 32'h0000ABCD, 32'h0, 32'h0}};

    rst_l = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0;
    seed = '0; step = '0; burst_len = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data",  out_data, 32'd0);
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_done",  {31'b0, done}, 32'd0);
    rst_l = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) run_vec(v);

    // WALK1 with downstream stall
    out_ready = 1'b0;
    launch(2'd2, 16'h8000, 16'd0, 16'd2);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall_valid%0d", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("stall_data%0d", i), out_data, 32'h00008000);
      tick();
    end
    out_ready = 1'b1;
    chk("stall_data_rel", out_data, 32'h00008000);
    tick();
    chk("stall_data_b2", out_data, 32'h00000001);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) dones++;
    end
    chk("stall_done_once", dones, 32'd1);

    // CONST unbounded across counter wrap, then abort
    launch(2'd3, 16'h1234, 16'd5, 16'd0);
    bad = 0; dones = 0;
    for (int i = 0; i < 70000; i++) begin
      if (out_valid !== 1'b1 || out_data !== 32'h00001234) bad++;
      if (done) dones++;
      tick();
    end
    chk("const_hold", bad, 32'd0);
    chk("const_no_done", dones, 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_busy",  {31'b0, busy}, 32'd0);
    chk("abort_done",  {31'b0, done}, 32'd0);
    tick();
    chk("abort_idle_done", {31'b0, done}, 32'd0);
    chk("abort_idle_valid", {31'b0, out_valid}, 32'd0);

    // Reset during beat 2 of a 5-beat burst
    launch(2'd0, 16'h0010, 16'd1, 16'd5);
    tick();
    chk("rstmid_b2", out_data, 32'h00000011);
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    chk("rstmid_valid", {31'b0, out_valid}, 32'd0);
    chk("rstmid_data",  out_data, 32'd0);
    chk("rstmid_busy",  {31'b0, busy}, 32'd0);
    chk("rstmid_done",  {31'b0, done}, 32'd0);
    launch(2'd0, 16'h0777, 16'd1, 16'd2);
    chk("rstmid_new0", out_data, 32'h00000777);
    tick();
    chk("rstmid_new1", out_data, 32'h00000778);
    tick();
    chk("rstmid_new_done", {31'b0, done}, 32'd1);
    tick();

    // start during RUN with different settings is ignored
    launch(2'd0, 16'd100, 16'd2, 16'd4);
    chk("ign_b0", out_data, 32'd100);
    start = 1'b1; mode = 2'd3; seed = 16'd9999; step = 16'd50; burst_len = 16'd1;
    tick();
    start = 1'b0;
    chk("ign_b1", out_data, 32'd102);
    tick();
    chk("ign_b2", out_data, 32'd104);
    tick();
    chk("ign_b3", out_data, 32'd106);
    tick();
    chk("ign_done", {31'b0, done}, 32'd1);
    tick();

    // abort alongside start in IDLE: start wins
    start = 1'b1; abort = 1'b1; mode = 2'd3; seed = 16'h00C3; burst_len = 16'd0;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("startwin_valid", {31'b0, out_valid}, 32'd1);
    chk("startwin_data",  out_data, 32'h000000C3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("startwin_abort", {31'b0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
